// File: rtl/piso_tx8.sv
// Parallel-in serial-out transmitter: start bit 0, WIDTH data bits LSB first, stop bit 1.
// Each bit is held for CLKS_PER_BIT clocks. Done pulses for one cycle on return to idle.
module piso_tx8 #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Din,
  input  logic             Load,
  output logic             Ready,
  output logic             Q,
  output logic             Qn,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  localparam int unsigned     BitW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [7:0]      CntMax = 8'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitMax = BitW'(WIDTH - 1);

  state_e           state_q;
  logic [7:0]       cnt_q;
  logic [BitW-1:0]  bit_q;
  logic [WIDTH-1:0] shift_q;
  logic             q_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             bit_end;

  assign bit_end = (cnt_q == CntMax);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      q_q     <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (Load) begin
            shift_q <= Din;
            cnt_q   <= '0;
            bit_q   <= '0;
            q_q     <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            cnt_q   <= '0;
            q_q     <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == BitMax) begin
              q_q     <= 1'b1;
              state_q <= StStop;
            end else begin
              // shift_q already holds the next bit in position 0
              bit_q   <= bit_q + 1'b1;
              q_q     <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StStop: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Q     = q_q;
  assign Qn    = ~q_q;
  assign Ready = ready_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_piso_tx8.sv
// Directed bench for piso_tx8: one instance at 1 clock/bit, one at 3 clocks/bit.
module tb_piso_tx8;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       load1, ready1, q1, qn1, busy1, done1;
  logic       load3, ready3, q3, qn3, busy3, done3;

  int checks;
  int failures;

  piso_tx8 #(.WIDTH(8), .CLKS_PER_BIT(1)) u_dut1 (
    .Clk(clk), .Rst(rst), .Din(din), .Load(load1), .Ready(ready1),
    .Q(q1), .Qn(qn1), .Busy(busy1), .Done(done1)
  );

  piso_tx8 #(.WIDTH(8), .CLKS_PER_BIT(3)) u_dut3 (
    .Clk(clk), .Rst(rst), .Din(din), .Load(load3), .Ready(ready3),
    .Q(q3), .Qn(qn3), .Busy(busy3), .Done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs observed 1ns after the edge; inputs changed there take effect at the next edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Vectors below are {Q, Qn, Ready, Busy, Done}.
  task automatic test_reset;
    logic [4:0] got;
    rst = 1'b1; load1 = 1'b0; load3 = 1'b0; din = 8'h00;
    tick();
    tick();
    got = {q1, qn1, ready1, busy1, done1};
    checks++;
    if (got !== 5'b10100) begin
      $display("FAIL reset_dut1 got=%b exp=%b", got, 5'b10100); failures++;
    end
    got = {q3, qn3, ready3, busy3, done3};
    checks++;
    if (got !== 5'b10100) begin
      $display("FAIL reset_dut3 got=%b exp=%b", got, 5'b10100); failures++;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      got = {q1, qn1, ready1, busy1, done1};
      checks++;
      if (got !== 5'b10100) begin
        $display("FAIL idle_after_reset c=%0d got=%b exp=%b", c, got, 5'b10100); failures++;
      end
    end
  endtask

  task automatic test_single;
    logic [9:0] fr;
    logic [4:0] got, exp;
    fr = 10'b0101001011;
    din = 8'hA5; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 10) exp = {fr[10-c], ~fr[10-c], 3'b010};
      else if (c == 11) exp = 5'b10101;
      else exp = 5'b10100;
      got = {q1, qn1, ready1, busy1, done1};
      checks++;
      if (got !== exp) begin
        $display("FAIL single_A5 c=%0d got=%b exp=%b", c, got, exp); failures++;
      end
      tick();
    end
  endtask

  task automatic test_ignored_load;
    logic [9:0] fr;
    logic [4:0] got, exp;
    fr = 10'b0101001011;
    din = 8'hA5; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c <= 10) exp = {fr[10-c], ~fr[10-c], 3'b010};
      else if (c == 11) exp = 5'b10101;
      else exp = 5'b10100;
      got = {q1, qn1, ready1, busy1, done1};
      checks++;
      if (got !== exp) begin
        $display("FAIL ignored_load c=%0d got=%b exp=%b", c, got, exp); failures++;
      end
      if (c == 4) begin
        load1 = 1'b1; din = 8'hFF;
      end else begin
        load1 = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [21:0] fr;
    logic [4:0]  got, exp;
    fr = 22'b0100000001_1_0000000011_1;
    din = 8'h01; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      if (c == 11 || c == 22) exp = 5'b10101;
      else exp = {fr[22-c], ~fr[22-c], 3'b010};
      got = {q1, qn1, ready1, busy1, done1};
      checks++;
      if (got !== exp) begin
        $display("FAIL back_to_back c=%0d got=%b exp=%b", c, got, exp); failures++;
      end
      if (c == 11) begin
        load1 = 1'b1; din = 8'h80;
      end else begin
        load1 = 1'b0;
        if (c == 12) din = 8'h55;
      end
      tick();
    end
  endtask

  task automatic test_stretch;
    logic [9:0] fr;
    logic [4:0] got, exp;
    int         idx;
    fr = 10'b0111100001;
    din = 8'h0F; load3 = 1'b1;
    tick();
    load3 = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      idx = 9 - (c - 1) / 3;
      if (c <= 30) exp = {fr[idx], ~fr[idx], 3'b010};
      else if (c == 31) exp = 5'b10101;
      else exp = 5'b10100;
      got = {q3, qn3, ready3, busy3, done3};
      checks++;
      if (got !== exp) begin
        $display("FAIL stretch_0F c=%0d got=%b exp=%b", c, got, exp); failures++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] fr;
    logic [4:0] got, exp;
    fr = 10'b0101001011;
    din = 8'hA5; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      exp = {fr[10-c], ~fr[10-c], 3'b010};
      got = {q1, qn1, ready1, busy1, done1};
      checks++;
      if (got !== exp) begin
        $display("FAIL mid_frame c=%0d got=%b exp=%b", c, got, exp); failures++;
      end
      if (c < 5) tick();
    end
    // Reset during data bit 3, with a competing Load
    rst = 1'b1; load1 = 1'b1;
    tick();
    rst = 1'b0; load1 = 1'b0;
    for (int c = 0; c < 14; c++) begin
      got = {q1, qn1, ready1, busy1, done1};
      checks++;
      if (got !== 5'b10100) begin
        $display("FAIL after_abort c=%0d got=%b exp=%b", c, got, 5'b10100); failures++;
      end
      tick();
    end
    fr = 10'b0001111001;
    din = 8'h3C; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c <= 10) exp = {fr[10-c], ~fr[10-c], 3'b010};
      else exp = 5'b10101;
      got = {q1, qn1, ready1, busy1, done1};
      checks++;
      if (got !== exp) begin
        $display("FAIL reload_3C c=%0d got=%b exp=%b", c, got, exp); failures++;
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_ignored_load();
    test_back_to_back();
    test_stretch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
